// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: opcodes,
// ALU operation codes, datapath mux selects, comparator codes, FSM state
// encoding and the bundled control-word type.
package riscv_ctrl_pkg;

    // FSM state encoding
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_ALU_WB  = 4'd4,
        S_MEM_ADR = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WB  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_JALR    = 4'd11,
        S_LUI     = 4'd12,
        S_AUIPC   = 4'd13
    } state_t;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Branch funct3 values that are supported
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LST = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NA  = 4'd15;

    // Comparator result codes
    localparam logic [1:0] COMP_EQU = 2'd0;
    localparam logic [1:0] COMP_LST = 2'd1;
    localparam logic [1:0] COMP_GRT = 2'd2;
    localparam logic [1:0] COMP_NA  = 2'd3;

    // Memory address select
    localparam logic ADDR_PC     = 1'b0;
    localparam logic ADDR_ALUOUT = 1'b1;

    // PC source select
    localparam logic PCSRC_ALURES = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;
    localparam logic [1:0] SRCB_ZERO = 2'd3;

    // Register writeback source select
    localparam logic [2:0] WB_MEM   = 3'd0;
    localparam logic [2:0] WB_ALU   = 3'd1;
    localparam logic [2:0] WB_PC4   = 3'd2;
    localparam logic [2:0] WB_IMM   = 3'd3;
    localparam logic [2:0] WB_PCIMM = 3'd4;

    // One complete control word, driven as a unit by the FSM
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       addr_src;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [2:0] wb_src;
        logic       illegal_instr;
        logic       bus_fault;
    } ctrl_t;

    // Quiet control word: no enables, no strobes, ALU idle
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c               = '0;
        c.alu_op        = ALU_NA;
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 of an R-type or I-type instruction onto an ALU
// operation code and flags combinations the datapath does not support.
import riscv_ctrl_pkg::*;

module alu_decoder (
    input  logic       i_is_rtype,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alu_op,
    output logic       o_valid
);

    // The ALU has no separate arithmetic-shift or unsigned-compare code:
    // sra/srai share SRL and sltu/sltiu share LST.
    // Funct decode for register and immediate arithmetic.
    always_comb begin
        o_alu_op = ALU_NA;
        o_valid  = 1'b0;
        if (i_is_rtype) begin
            case (i_funct7)
                F7_BASE: begin
                    o_valid = 1'b1;
                    case (i_funct3)
                        3'd0:    o_alu_op = ALU_ADD;
                        3'd1:    o_alu_op = ALU_SLL;
                        3'd2:    o_alu_op = ALU_LST;
                        3'd3:    o_alu_op = ALU_LST;
                        3'd4:    o_alu_op = ALU_XOR;
                        3'd5:    o_alu_op = ALU_SRL;
                        3'd6:    o_alu_op = ALU_OR;
                        default: o_alu_op = ALU_AND;
                    endcase
                end
                F7_ALT: begin
                    if (i_funct3 == 3'd0) begin
                        o_valid  = 1'b1;
                        o_alu_op = ALU_SUB;
                    end else if (i_funct3 == 3'd5) begin
                        o_valid  = 1'b1;
                        o_alu_op = ALU_SRL;
                    end
                end
                F7_MULDIV: begin
                    if (i_funct3 == 3'd0) begin
                        o_valid  = 1'b1;
                        o_alu_op = ALU_MUL;
                    end else if (i_funct3 == 3'd4) begin
                        o_valid  = 1'b1;
                        o_alu_op = ALU_DIV;
                    end
                end
                default: begin
                    o_valid  = 1'b0;
                end
            endcase
        end else begin
            // For immediates funct7 is only meaningful for the shifts.
            case (i_funct3)
                3'd0: begin
                    o_valid  = 1'b1;
                    o_alu_op = ALU_ADD;
                end
                3'd1: begin
                    if (i_funct7 == F7_BASE) begin
                        o_valid  = 1'b1;
                        o_alu_op = ALU_SLL;
                    end
                end
                3'd2, 3'd3: begin
                    o_valid  = 1'b1;
                    o_alu_op = ALU_LST;
                end
                3'd4: begin
                    o_valid  = 1'b1;
                    o_alu_op = ALU_XOR;
                end
                3'd5: begin
                    if ((i_funct7 == F7_BASE) || (i_funct7 == F7_ALT)) begin
                        o_valid  = 1'b1;
                        o_alu_op = ALU_SRL;
                    end
                end
                3'd6: begin
                    o_valid  = 1'b1;
                    o_alu_op = ALU_OR;
                end
                default: begin
                    o_valid  = 1'b1;
                    o_alu_op = ALU_AND;
                end
            endcase
        end
    end

endmodule

// File: rtl/main_controller_multicycle.sv
// Multicycle RISC-V main controller. A Moore-style FSM sequences fetch,
// decode, execute, memory and writeback; the memory states wait on a
// bounded handshake and abort with a BusFault pulse when it times out.
//
// Memory handshake: in FETCH, MEM_RD and MEM_WR the controller holds
// MemRead or MemWrite high and stays put until the cycle in which MemReady
// is 1; that cycle completes the access. If MemReady stays low for
// MEM_TIMEOUT consecutive cycles, the last of them drops the strobe,
// pulses BusFault and returns to FETCH. MemReady in that same cycle wins.
import riscv_ctrl_pkg::*;

module main_controller_multicycle #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic [1:0] i_comp,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_addr_src,
    output logic       o_pc_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_alu_op,
    output logic [2:0] o_writeback_src,
    output logic       o_illegal_instr,
    output logic       o_bus_fault,
    output logic [3:0] o_dbg_state
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_in_mem;
    logic             w_timeout;
    logic             w_cnt_clr;
    logic             w_dec_valid;
    logic [3:0]       w_dec_op;
    logic             w_br_taken;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;

    alu_decoder u_alu_decoder (
        .i_is_rtype (i_opcode == OP_R),
        .i_funct3   (i_funct3),
        .i_funct7   (i_funct7),
        .o_alu_op   (w_dec_op),
        .o_valid    (w_dec_valid)
    );

    assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
    // The counter holds cycles already waited, so the abort lands on the
    // MEM_TIMEOUT-th consecutive cycle without MemReady.
    assign w_timeout  = w_in_mem && !i_mem_ready && (r_wait_cnt == CNT_LAST);
    // Any state change (or a FETCH retry) starts a fresh wait window.
    assign w_cnt_clr  = (w_next != r_state) || w_timeout;
    assign w_br_taken = ((i_funct3 == F3_BEQ) && (i_comp == COMP_EQU)) ||
                        ((i_funct3 == F3_BNE) && (i_comp != COMP_EQU));

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: counts stalled cycles in the waiting states.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_cnt_clr) begin
            r_wait_cnt <= '0;
        end else if (w_in_mem && !i_mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        w_next = r_state;
        w_ctrl = ctrl_idle();
        case (r_state)
            S_FETCH: begin
                if (w_timeout) begin
                    w_ctrl.bus_fault = 1'b1;
                    w_next           = S_FETCH;
                end else begin
                    w_ctrl.addr_src = ADDR_PC;
                    w_ctrl.mem_read = 1'b1;
                    if (i_mem_ready) begin
                        w_ctrl.ir_write  = 1'b1;
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.alu_src_a = SRCA_PC;
                        w_ctrl.alu_src_b = SRCB_FOUR;
                        w_ctrl.alu_op    = ALU_ADD;
                        w_ctrl.pc_src    = PCSRC_ALURES;
                        w_next           = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                // ALUOut captures OldPC + Imm as the branch/jump target.
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_next           = S_FETCH;
                case (i_opcode)
                    OP_R:      w_next = w_dec_valid ? S_EXEC_R : S_FETCH;
                    OP_I:      w_next = w_dec_valid ? S_EXEC_I : S_FETCH;
                    OP_LOAD:   w_next = S_MEM_ADR;
                    OP_STORE:  w_next = S_MEM_ADR;
                    OP_BRANCH: w_next = ((i_funct3 == F3_BEQ) || (i_funct3 == F3_BNE)) ?
                                        S_BRANCH : S_FETCH;
                    OP_JAL:    w_next = S_JAL;
                    OP_JALR:   w_next = S_JALR;
                    OP_LUI:    w_next = S_LUI;
                    OP_AUIPC:  w_next = S_AUIPC;
                    default:   w_next = S_FETCH;
                endcase
                if (w_next == S_FETCH) begin
                    w_ctrl.illegal_instr = 1'b1;
                end
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = w_dec_op;
                w_next           = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = w_dec_op;
                w_next           = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_ALU;
                w_next           = S_FETCH;
            end
            S_MEM_ADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_next           = (i_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (w_timeout) begin
                    w_ctrl.bus_fault = 1'b1;
                    w_next           = S_FETCH;
                end else begin
                    w_ctrl.addr_src = ADDR_ALUOUT;
                    w_ctrl.mem_read = 1'b1;
                    if (i_mem_ready) begin
                        w_next = S_MEM_WB;
                    end
                end
            end
            S_MEM_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_MEM;
                w_next           = S_FETCH;
            end
            S_MEM_WR: begin
                if (w_timeout) begin
                    w_ctrl.bus_fault = 1'b1;
                    w_next           = S_FETCH;
                end else begin
                    w_ctrl.addr_src  = ADDR_ALUOUT;
                    w_ctrl.mem_write = 1'b1;
                    if (i_mem_ready) begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = PCSRC_ALUOUT;
                w_ctrl.pc_write  = w_br_taken;
                w_next           = S_FETCH;
            end
            S_JAL: begin
                w_ctrl.pc_src    = PCSRC_ALUOUT;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_PC4;
                w_next           = S_FETCH;
            end
            S_JALR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.pc_src    = PCSRC_ALURES;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_PC4;
                w_next           = S_FETCH;
            end
            S_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_IMM;
                w_next           = S_FETCH;
            end
            S_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_src    = WB_PCIMM;
                w_next           = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset silences every output immediately, even mid-instruction.
    assign w_out = i_rst ? ctrl_idle() : w_ctrl;

    assign o_pc_write      = w_out.pc_write;
    assign o_ir_write      = w_out.ir_write;
    assign o_reg_write     = w_out.reg_write;
    assign o_mem_read      = w_out.mem_read;
    assign o_mem_write     = w_out.mem_write;
    assign o_addr_src      = w_out.addr_src;
    assign o_pc_src        = w_out.pc_src;
    assign o_alu_src_a     = w_out.alu_src_a;
    assign o_alu_src_b     = w_out.alu_src_b;
    assign o_alu_op        = w_out.alu_op;
    assign o_writeback_src = w_out.wb_src;
    assign o_illegal_instr = w_out.illegal_instr;
    assign o_bus_fault     = w_out.bus_fault;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_main_controller_multicycle.sv
// Self-checking bench for main_controller_multicycle. Each directed
// instruction is expanded into its expected per-cycle control words from
// the instruction-level rules, and a compare process checks every cycle.
module tb_main_controller_multicycle;

  localparam int T = 15;
  localparam int W = 20;

  // Encodings as given by the controller's interface description
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_NA = 4'd15;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst = 1'b1;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic [6:0] i_funct7 = '0;
  logic [1:0] i_comp = '0;
  logic       i_mem_ready = 1'b0;
  logic o_pc_write, o_ir_write, o_reg_write, o_mem_read, o_mem_write;
  logic o_addr_src, o_pc_src, o_illegal_instr, o_bus_fault;
  logic [1:0] o_alu_src_a, o_alu_src_b;
  logic [3:0] o_alu_op, o_dbg_state;
  logic [2:0] o_writeback_src;
  logic [W-1:0] dut_w;

  main_controller_multicycle #(.MEM_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7(i_funct7), .i_comp(i_comp), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_addr_src(o_addr_src),
    .o_pc_src(o_pc_src), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_writeback_src(o_writeback_src),
    .o_illegal_instr(o_illegal_instr), .o_bus_fault(o_bus_fault),
    .o_dbg_state(o_dbg_state)
  );

  assign dut_w = {o_pc_write, o_ir_write, o_reg_write, o_mem_read, o_mem_write,
                  o_addr_src, o_pc_src, o_alu_src_a, o_alu_src_b, o_alu_op,
                  o_writeback_src, o_illegal_instr, o_bus_fault};

  // Control word: pcw irw rw mr mw as ps a b op wb ill bf
  function automatic logic [W-1:0] ov(input logic pcw, irw, rw, mr, mw, as_, ps,
                                      input logic [1:0] a, b, input logic [3:0] op,
                                      input logic [2:0] wb, input logic ill, bf);
    return {pcw, irw, rw, mr, mw, as_, ps, a, b, op, wb, ill, bf};
  endfunction

  function automatic logic [W-1:0] idle_w();
    return ov(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd0, 0, 0);
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int n_tests = 0, n_fail = 0, n_cyc = 0;
  int n_bf = 0, n_ill = 0, n_rw = 0, n_rd_alu = 0;

  initial begin
    forever begin
      @(negedge clk);
      n_cyc++;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        if (dut_w !== e) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %05h exp %05h (state %0d)", t, n_cyc, dut_w, e, o_dbg_state);
        end
        n_bf     += int'(o_bus_fault);
        n_ill    += int'(o_illegal_instr);
        n_rw     += int'(o_reg_write);
        n_rd_alu += int'(o_mem_read && o_addr_src);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step(input logic r, input logic rdy, input logic [W-1:0] e, input string t);
    i_rst = r;
    i_mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // A waiting access: `delay` cycles without MemReady, then MemReady.
  // The T-th consecutive stall aborts with BusFault; FETCH retries.
  task automatic mem_phase(input int delay, input logic is_fetch, input logic is_wr,
                           output logic faulted);
    int waits;
    logic [W-1:0] wait_w, rdy_w;
    waits = 0;
    faulted = 1'b0;
    if (is_fetch) begin
      wait_w = ov(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd0, 0, 0);
      rdy_w  = ov(1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd2, A_ADD, 3'd0, 0, 0);
    end else begin
      wait_w = ov(0, 0, 0, !is_wr, is_wr, 1, 0, 2'd0, 2'd0, A_NA, 3'd0, 0, 0);
      rdy_w  = wait_w;
    end
    for (int c = 0; c < delay; c++) begin
      waits++;
      if (waits == T) begin
        step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd0, 0, 1), "bus_fault");
        waits = 0;
        if (!is_fetch) begin
          faulted = 1'b1;
          break;
        end
      end else begin
        step(0, 0, wait_w, is_fetch ? "fetch_wait" : "mem_wait");
      end
    end
    if (!faulted) step(0, 1, rdy_w, is_fetch ? "fetch_done" : "mem_done");
  endtask

  task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [1:0] cmp, input logic [3:0] eop, input logic legal,
                     input int fd, input int md);
    logic flt;
    logic taken;
    i_opcode = opc;
    i_funct3 = f3;
    i_funct7 = f7;
    i_comp   = cmp;
    mem_phase(fd, 1'b1, 1'b0, flt);
    step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, A_ADD, 3'd0, !legal, 0), "decode");
    if (legal) begin
      case (opc)
        OPC_R: begin
          step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, eop, 3'd0, 0, 0), "exec_r");
          step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd1, 0, 0), "alu_wb");
        end
        OPC_I: begin
          step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, eop, 3'd0, 0, 0), "exec_i");
          step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd1, 0, 0), "alu_wb");
        end
        OPC_LD: begin
          step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, A_ADD, 3'd0, 0, 0), "mem_adr");
          mem_phase(md, 1'b0, 1'b0, flt);
          if (!flt) step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd0, 0, 0), "mem_wb");
        end
        OPC_ST: begin
          step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, A_ADD, 3'd0, 0, 0), "mem_adr");
          mem_phase(md, 1'b0, 1'b1, flt);
        end
        OPC_BR: begin
          taken = ((f3 == 3'd0) && (cmp == 2'd0)) || ((f3 == 3'd1) && (cmp != 2'd0));
          step(0, 0, ov(taken, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, A_SUB, 3'd0, 0, 0), "branch");
        end
        OPC_JAL:   step(0, 0, ov(1, 0, 1, 0, 0, 0, 1, 2'd0, 2'd0, A_NA, 3'd2, 0, 0), "jal");
        OPC_JALR:  step(0, 0, ov(1, 0, 1, 0, 0, 0, 0, 2'd2, 2'd1, A_ADD, 3'd2, 0, 0), "jalr");
        OPC_LUI:   step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd3, 0, 0), "lui");
        OPC_AUIPC: step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, A_NA, 3'd4, 0, 0), "auipc");
        default:   $display("bench: no expansion for opcode %b", opc);
      endcase
    end
  endtask

  task automatic check_int(input string t, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", t, got, exp);
    end
  endtask

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op;
    logic       legal;
  } vec_t;

  vec_t tbl[27];

  initial begin
    tbl = '{
      '{OPC_R, 3'd0, 7'h00, 4'd0, 1'b1},  // add
      '{OPC_R, 3'd0, 7'h20, 4'd1, 1'b1},  // sub
      '{OPC_R, 3'd4, 7'h00, 4'd2, 1'b1},  // xor
      '{OPC_R, 3'd6, 7'h00, 4'd3, 1'b1},  // or
      '{OPC_R, 3'd7, 7'h00, 4'd4, 1'b1},  // and
      '{OPC_R, 3'd1, 7'h00, 4'd5, 1'b1},  // sll
      '{OPC_R, 3'd5, 7'h00, 4'd6, 1'b1},  // srl
      '{OPC_R, 3'd5, 7'h20, 4'd6, 1'b1},  // sra
      '{OPC_R, 3'd2, 7'h00, 4'd7, 1'b1},  // slt
      '{OPC_R, 3'd3, 7'h00, 4'd7, 1'b1},  // sltu
      '{OPC_R, 3'd0, 7'h01, 4'd8, 1'b1},  // mul
      '{OPC_R, 3'd4, 7'h01, 4'd9, 1'b1},  // div
      '{OPC_I, 3'd0, 7'h55, 4'd0, 1'b1},  // addi (imm bits in funct7)
      '{OPC_I, 3'd4, 7'h00, 4'd2, 1'b1},  // xori
      '{OPC_I, 3'd6, 7'h00, 4'd3, 1'b1},  // ori
      '{OPC_I, 3'd7, 7'h00, 4'd4, 1'b1},  // andi
      '{OPC_I, 3'd1, 7'h00, 4'd5, 1'b1},  // slli
      '{OPC_I, 3'd5, 7'h00, 4'd6, 1'b1},  // srli
      '{OPC_I, 3'd5, 7'h20, 4'd6, 1'b1},  // srai
      '{OPC_I, 3'd2, 7'h00, 4'd7, 1'b1},  // slti
      '{OPC_I, 3'd3, 7'h00, 4'd7, 1'b1},  // sltiu
      '{OPC_R, 3'd0, 7'h10, 4'd15, 1'b0}, // bad funct7
      '{OPC_R, 3'd1, 7'h01, 4'd15, 1'b0}, // mulh unsupported
      '{OPC_I, 3'd1, 7'h20, 4'd15, 1'b0}, // bad slli
      '{OPC_I, 3'd5, 7'h10, 4'd15, 1'b0}, // bad shift-right
      '{7'b0000000, 3'd0, 7'h00, 4'd15, 1'b0}, // opcode 0
      '{OPC_BR, 3'd2, 7'h00, 4'd15, 1'b0}      // unsupported branch funct3
    };

    // reset: outputs silent even with MemReady high
    step(1, 0, idle_w(), "reset0");
    step(1, 1, idle_w(), "reset1");

    // ALU, illegal-decode table; fetch latency varies 0..2
    foreach (tbl[i]) run(tbl[i].opc, tbl[i].f3, tbl[i].f7, 2'd0, tbl[i].op, tbl[i].legal, i % 3, 0);

    // loads and stores
    run(OPC_LD, 3'd2, 7'h00, 2'd0, A_NA, 1'b1, 0, 3);
    run(OPC_ST, 3'd2, 7'h00, 2'd0, A_NA, 1'b1, 1, 1);
    run(OPC_ST, 3'd2, 7'h00, 2'd0, A_NA, 1'b1, 0, 0);

    // branches: beq EQU/LST, bne GRT/EQU
    run(OPC_BR, 3'd0, 7'h00, 2'd0, A_NA, 1'b1, 0, 0);
    run(OPC_BR, 3'd0, 7'h00, 2'd1, A_NA, 1'b1, 0, 0);
    run(OPC_BR, 3'd1, 7'h00, 2'd2, A_NA, 1'b1, 0, 0);
    run(OPC_BR, 3'd1, 7'h00, 2'd0, A_NA, 1'b1, 0, 0);

    // jumps and upper immediates
    run(OPC_JAL,   3'd0, 7'h00, 2'd3, A_NA, 1'b1, 0, 0);
    run(OPC_JALR,  3'd0, 7'h00, 2'd3, A_NA, 1'b1, 1, 0);
    run(OPC_LUI,   3'd0, 7'h00, 2'd3, A_NA, 1'b1, 0, 0);
    run(OPC_AUIPC, 3'd0, 7'h00, 2'd3, A_NA, 1'b1, 2, 0);

    // fetch timeout then retry; MemReady exactly on the limit cycle wins
    run(OPC_I,   3'd0, 7'h00, 2'd0, A_ADD, 1'b1, T, 0);
    run(OPC_LUI, 3'd0, 7'h00, 2'd0, A_NA,  1'b1, T - 1, 0);

    // load whose data phase times out
    run(OPC_LD, 3'd2, 7'h00, 2'd0, A_NA, 1'b1, 0, T + 3);

    // reset in the middle of a store's memory phase
    i_opcode = OPC_ST;
    i_funct3 = 3'd2;
    i_funct7 = 7'h00;
    step(0, 1, ov(1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd2, A_ADD, 3'd0, 0, 0), "st_fetch");
    step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, A_ADD, 3'd0, 0, 0), "st_decode");
    step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, A_ADD, 3'd0, 0, 0), "st_adr");
    step(0, 0, ov(0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, A_NA, 3'd0, 0, 0), "st_memwr");
    step(1, 1, idle_w(), "rst_in_memwr");
    run(OPC_R, 3'd0, 7'h00, 2'd0, A_ADD, 1'b1, 1, 0);

    // hand-counted totals over the whole run
    check_int("regwrite_cycles", n_rw, 29);
    check_int("illegal_pulses", n_ill, 6);
    check_int("busfault_pulses", n_bf, 2);
    check_int("mem_read_aluout_cycles", n_rd_alu, 18);
    check_int("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/main_controller_multicycle.md
MAIN_CONTROLLER_MULTICYCLE -- requirements
Module: main_controller_multicycle

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles a memory state waits for MemReady before it aborts.
REQ-002 clk  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Opcode/Funct3/Funct7  input  7/3/7  fields of the instruction register.
REQ-005 Comp  input  2  register comparator result: 0=EQU, 1=LST, 2=GRT, 3=NA.
REQ-006 MemReady  input  1  memory completion handshake for the current MemRead or MemWrite.
REQ-007 PCWrite, IRWrite, RegWrite, MemRead, MemWrite  output  1 each  enables and strobes.
REQ-008 AddrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 PCSrc  output  1  PC source select: 0=ALUResult, 1=ALUOut.
REQ-010 ALUSrcA  output  2  ALU A operand: 0=PC, 1=OldPC, 2=RS1, 3=zero.
REQ-011 ALUSrcB  output  2  ALU B operand: 0=RS2, 1=Imm, 2=const 4, 3=zero.
REQ-012 ALUOp  output  4  ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, LST=7, MUL=8, DIV=9, NA=15.
REQ-013 WritebackSrc  output  3  0=MemData, 1=ALUOut, 2=PC_4, 3=Imm, 4=PC_Imm.
REQ-014 IllegalInstr, BusFault  output  1 each  single-cycle error pulses.

Function
REQ-015 The controller SHALL be a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, LUI, AUIPC.
REQ-016 Every output not listed for a state SHALL be 0; ALUOp SHALL default to NA.
REQ-017 FETCH: AddrSrc=0, MemRead=1, and the FSM SHALL hold in FETCH until MemReady=1.
REQ-018 In the FETCH cycle where MemReady=1, the FSM SHALL assert IRWrite=1 and PCWrite=1, with ALUSrcA=0, ALUSrcB=2, ALUOp=ADD and PCSrc=0, and SHALL then enter DECODE.
REQ-019 DECODE: ALUSrcA=1, ALUSrcB=1, ALUOp=ADD (ALUOut latches the branch or jump target); the next state SHALL be selected by Opcode.
REQ-020 Opcode to next state: R-type 0110011 -> EXEC_R; I-type 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADR; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
REQ-021 EXEC_R: ALUSrcA=2, ALUSrcB=0. EXEC_I: ALUSrcA=2, ALUSrcB=1. In both, ALUOp SHALL come from the funct decode (add/sub/xor/or/and/sll/srl/sra/slt/sltu/mul/div), and the next state SHALL be ALU_WB.
REQ-022 ALU_WB: RegWrite=1, WritebackSrc=1, then the FSM SHALL return to FETCH.
REQ-023 MEM_ADR: ALUSrcA=2, ALUSrcB=1, ALUOp=ADD; next state SHALL be MEM_RD for a load and MEM_WR for a store.
REQ-024 MEM_RD: AddrSrc=1, MemRead=1, held until MemReady=1, then MEM_WB. MEM_WB: RegWrite=1, WritebackSrc=0, then FETCH.
REQ-025 MEM_WR: AddrSrc=1, MemWrite=1, held until MemReady=1, then FETCH.
REQ-026 BRANCH: ALUSrcA=2, ALUSrcB=0, ALUOp=SUB, PCSrc=1; PCWrite SHALL be 1 when (Funct3=0 and Comp=EQU) or (Funct3=1 and Comp!=EQU); the next state SHALL be FETCH.
REQ-027 JAL: PCSrc=1, PCWrite=1, RegWrite=1, WritebackSrc=2, then FETCH.
REQ-028 JALR: ALUSrcA=2, ALUSrcB=1, ALUOp=ADD, PCSrc=0, PCWrite=1, RegWrite=1, WritebackSrc=2, then FETCH.
REQ-029 LUI: RegWrite=1, WritebackSrc=3. AUIPC: RegWrite=1, WritebackSrc=4. Both SHALL then go to FETCH.
REQ-030 An unsupported opcode, funct combination, or branch Funct3 seen in DECODE SHALL pulse IllegalInstr for one cycle, make no writes, and return to FETCH.
REQ-031 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle MemReady=0.
REQ-032 If the wait counter reaches MEM_TIMEOUT, the FSM SHALL pulse BusFault, deassert MemRead/MemWrite, make no writes, and go to FETCH (retrying the same PC).
REQ-033 If MemReady=1 arrives in the same cycle the counter reaches MEM_TIMEOUT, MemReady SHALL win.

Reset
REQ-034 While rst=1, the state SHALL be forced to FETCH, the wait counter cleared, and all outputs driven to 0 (ALUOp=NA), including the cycle of a reset asserted mid-instruction.
REQ-035 In the first cycle after rst deasserts, the FSM SHALL be in FETCH with MemRead=1.

Structure
REQ-036 Opcodes, ALUOp codes, mux-select codes, Comp codes and the state encoding SHALL live in shared package riscv_ctrl_pkg.
REQ-037 The funct-to-ALUOp mapping SHALL be implemented as sub-module alu_decoder.

Verification
REQ-038 add x3,x1,x2 with MemReady=1 -> FETCH, DECODE, EXEC_R, ALU_WB over 4 cycles; RegWrite=1 only in cycle 4, with WritebackSrc=1.
REQ-039 lw with MemReady delayed 3 cycles in MEM_RD -> MemRead held 4 cycles, then MEM_WB with RegWrite=1 and WritebackSrc=0.
REQ-040 beq with Comp=EQU -> PCWrite=1 and PCSrc=1 in BRANCH; beq with Comp=LST -> PCWrite=0.
REQ-041 MemReady held 0 in FETCH with MEM_TIMEOUT=15 -> BusFault pulses on cycle 15, and FETCH restarts with no PCWrite or IRWrite.
REQ-042 Opcode 0000000 -> IllegalInstr pulses in DECODE, and no RegWrite, MemWrite or PCWrite follows.
REQ-043 rst asserted during MEM_WR -> MemWrite=0 in that cycle, and FETCH with MemRead=1 in the cycle after release.
